// File: rtl/pwm_generator.sv
// pwm_generator: prescaler + 255-tick period counter driving 16 low/high/PWM outputs.
// Build option: define PWM_SHADOW_EN to double-buffer duty and PWM-mode select at period boundaries.
module pwm_generator #(
  parameter int unsigned PRESCALE = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_tick
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  PER_LAST = 8'd254;

  logic [15:0] r_pre_cnt;
  logic [7:0]  r_per_cnt;
  logic [15:0] r_out;
  logic        r_period_tick;

  logic        w_tick;
  logic        w_boundary;
  logic        w_pwm_lvl;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_pwm_en_eff;
  logic [7:0]  w_duty_eff;
  logic [15:0] w_out_nxt;

  assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_tick     = (r_pre_cnt == PRE_LAST);
  assign w_boundary = w_tick && (r_per_cnt == PER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end

  // Period is 0..254, so a duty of 0xFF never sees per_cnt catch up and stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_cnt <= '0;
    end else if (w_tick) begin
      r_per_cnt <= (r_per_cnt == PER_LAST) ? 8'd0 : r_per_cnt + 8'd1;
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0]  r_duty_sh;
  logic [15:0] r_pwm_en_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_sh   <= '0;
      r_pwm_en_sh <= '0;
    end else if (w_boundary) begin
      r_duty_sh   <= pwm_duty_cycle;
      r_pwm_en_sh <= w_en_pwm;
    end
  end

  assign w_duty_eff   = r_duty_sh;
  assign w_pwm_en_eff = r_pwm_en_sh;
`else
  assign w_duty_eff   = pwm_duty_cycle;
  assign w_pwm_en_eff = w_en_pwm;
`endif

  assign w_pwm_lvl = (r_per_cnt < w_duty_eff);
  assign w_out_nxt = w_en_out & (~w_pwm_en_eff | {16{w_pwm_lvl}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_out         <= w_out_nxt;
      r_period_tick <= w_boundary;
    end
  end

  assign out_7_0     = r_out[7:0];
  assign out_15_8    = r_out[15:8];
  assign period_tick = r_period_tick;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator (PRESCALE=2) against a cycle-count based reference model.
// Honours PWM_SHADOW_EN the same way as the design.
module tb_pwm_generator;

  localparam int P   = 2;
  localparam int PER = 255 * P;

  logic       clk;
  logic       rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic [7:0] out_7_0, out_15_8;
  logic       period_tick;
  logic [15:0] dut_out;

  int checks = 0;
  int errors = 0;

  pwm_generator #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .out_7_0(out_7_0), .out_15_8(out_15_8), .period_tick(period_tick)
  );

  assign dut_out = {out_15_8, out_7_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: m_n = edges since reset release (mod one period); counters follow from arithmetic.
  int          m_n;
  int          m_per;
  logic [7:0]  m_d;
  logic [15:0] m_pe;
  logic [15:0] m_en;
  logic [15:0] m_out;
  logic        m_tick;
`ifdef PWM_SHADOW_EN
  logic [7:0]  m_duty_sh;
  logic [15:0] m_pen_sh;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_out = '0; m_tick = 1'b0;
`ifdef PWM_SHADOW_EN
      m_duty_sh = '0; m_pen_sh = '0;
`endif
    end else begin
      m_per = (m_n / P) % 255;
      m_en  = {en_reg_out_15_8, en_reg_out_7_0};
`ifdef PWM_SHADOW_EN
      m_d = m_duty_sh; m_pe = m_pen_sh;
`else
      m_d = pwm_duty_cycle; m_pe = {en_reg_pwm_15_8, en_reg_pwm_7_0};
`endif
      for (int i = 0; i < 16; i++)
        m_out[i] = !m_en[i] ? 1'b0 : (!m_pe[i] ? 1'b1 : (m_per < int'(m_d)));
      m_tick = ((m_n % PER) == PER - 1);
`ifdef PWM_SHADOW_EN
      if (m_tick) begin
        m_duty_sh = pwm_duty_cycle;
        m_pen_sh  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      end
`endif
      m_n = (m_n + 1) % PER;
    end
  end

  task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  task automatic wait_boundary(input string name);
    bit found = 0;
    for (int k = 0; k < PER + 20; k++) begin
      @(negedge clk);
      if (m_tick) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s boundary: none within %0d cycles, expected one", name, PER + 20);
    end
  endtask

  task automatic test_reset_initial();
    rst = 1'b1;
    set_inputs(16'h0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (dut_out !== 16'h0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: out=%h tick=%b expected out=0000 tick=0", dut_out, period_tick);
    end
    rst = 1'b0;
  endtask

  task automatic test_static_enable();
    set_inputs(16'h0001, 16'h0000, 8'h80);
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      checks++;
      if (out_7_0 !== 8'h01 || out_15_8 !== 8'h00) begin
        errors++;
        $display("FAIL static_enable cyc %0d: out=%h expected 0001", j, dut_out);
      end
    end
    set_inputs(16'h0000, 16'h0000, 8'h80);
    @(negedge clk);
    checks++;
    if (dut_out !== 16'h0000) begin
      errors++;
      $display("FAIL static_disable: out=%h expected 0000", dut_out);
    end
  endtask

  task automatic test_reset_mid_period();
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== m_out || period_tick !== m_tick) begin
        errors++;
        $display("FAIL reset_pre model: out=%h exp=%h tick=%b exp=%b", dut_out, m_out, period_tick, m_tick);
      end
    end
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== 16'h0 || period_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: out=%h tick=%b expected 0000/0", j, dut_out, period_tick);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      checks++;
      if (period_tick !== (j == PER) || dut_out !== m_out) begin
        errors++;
        $display("FAIL reset_restart cyc %0d: tick=%b exp=%b out=%h exp=%h", j, period_tick, (j == PER), dut_out, m_out);
      end
    end
  endtask

  task automatic test_duty_50();
    int hi = 0, ticks = 0, bad = 0;
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    wait_boundary("duty_50");
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (dut_out === 16'hFFFF) hi++;
      else if (dut_out !== 16'h0000) bad++;
      if (period_tick === 1'b1) ticks++;
      if (j == PER && period_tick !== 1'b1) bad++;
    end
    checks++;
    if (hi != 256 || ticks != 1 || bad != 0) begin
      errors++;
      $display("FAIL duty_50: high=%0d ticks=%0d bad=%0d expected high=256 ticks=1 bad=0", hi, ticks, bad);
    end
  endtask

  task automatic test_duty_extremes();
    logic [7:0]  duty [2];
    logic [15:0] lvl  [2];
    int bad;
    duty[0] = 8'h00; lvl[0] = 16'h0000;
    duty[1] = 8'hFF; lvl[1] = 16'hFFFF;
    for (int t = 0; t < 2; t++) begin
      set_inputs(16'hFFFF, 16'hFFFF, duty[t]);
      wait_boundary("duty_extreme");
      bad = 0;
      for (int j = 1; j <= PER + 10; j++) begin
        @(negedge clk);
        if (dut_out !== lvl[t]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL duty_extreme %h: %0d cycles differed from %h", duty[t], bad, lvl[t]);
      end
    end
  endtask

  task automatic test_shadowing();
    int hi1 = 0, hi2 = 0;
    set_inputs(16'hFFFF, 16'hFFFF, 8'h40);
    wait_boundary("shadow");
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (dut_out === 16'hFFFF) hi1++;
      if (j == 256) begin
        checks++;
`ifdef PWM_SHADOW_EN
        if (dut_out !== 16'h0000) begin
          errors++;
          $display("FAIL shadow_hold: out=%h expected 0000", dut_out);
        end
`else
        if (dut_out !== 16'hFFFF) begin
          errors++;
          $display("FAIL shadow_live: out=%h expected ffff", dut_out);
        end
`endif
      end
      if (j == 255) pwm_duty_cycle = 8'hC0;
    end
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (dut_out === 16'hFFFF) hi2++;
    end
`ifdef PWM_SHADOW_EN
    checks++;
    if (hi1 != 128) begin
      errors++;
      $display("FAIL shadow_old_high: high=%0d expected 128", hi1);
    end
`endif
    checks++;
    if (hi2 != 384) begin
      errors++;
      $display("FAIL shadow_new_high: high=%0d expected 384", hi2);
    end
  endtask

  task automatic test_mixed();
    int pulse = 0, bad = 0;
    set_inputs(16'h00FF, 16'h000F, 8'h01);
    wait_boundary("mixed");
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (out_7_0[3:0] === 4'hF) pulse++;
      else if (out_7_0[3:0] !== 4'h0) bad++;
      if (out_7_0[7:4] !== 4'hF || out_15_8 !== 8'h00) bad++;
    end
    checks++;
    if (pulse != P || bad != 0) begin
      errors++;
      $display("FAIL mixed: pulse=%0d bad=%0d expected pulse=%0d bad=0", pulse, bad, P);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int j = 0; j < 4000; j++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== m_out || period_tick !== m_tick) begin
        errors++;
        $display("FAIL random cyc %0d: out=%h exp=%h tick=%b exp=%b", j, dut_out, m_out, period_tick, m_tick);
      end
      if ($urandom_range(0, 99) < 4) {en_reg_out_15_8, en_reg_out_7_0} = 16'($urandom);
      if ($urandom_range(0, 99) < 4) {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'($urandom);
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 3))
          0:       d = 8'h00;
          1:       d = 8'hFF;
          default: d = 8'($urandom);
        endcase
        pwm_duty_cycle = d;
      end
      rst = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset_initial();
    test_static_enable();
    test_reset_mid_period();
    test_duty_50();
    test_duty_extremes();
    test_shadowing();
    test_mixed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
